hcsr04_echo_emulator: RTL
=========================

HCSR04_ECHO_EMULATOR -- requirements
Module: hcsr04_echo_emulator

Interface
REQ-001 The block SHALL expose parameter CLK_FREQ_MHZ, default 100, meaning clk cycles per microsecond.
REQ-002 The block SHALL expose parameter MIN_TRIG_US, default 10, meaning the minimum valid trigger high width in us.
REQ-003 The block SHALL expose parameter BURST_DELAY_US, default 200, meaning the delay from trigger fall to echo rise in us.
REQ-004 The block SHALL expose parameter US_PER_CM, default 58, meaning echo width per cm in us.
REQ-005 The block SHALL expose parameters MIN_CM and MAX_CM, defaults 2 and 400, meaning the valid range limits.
REQ-006 The block SHALL expose parameter TIMEOUT_US, default 38000, meaning the out-of-range echo width in us.
REQ-007 The block SHALL expose parameter HOLDOFF_US, default 10000, meaning the dead time after echo fall in us.
REQ-008 clk  input  1  system clock.
REQ-009 reset_p  input  1  reset, asynchronous, active-high.
REQ-010 trigger  input  1  asynchronous trigger from the controller under test.
REQ-011 distance_cm  input  16  emulated target distance in cm.
REQ-012 echo  output  1  emulated echo pulse, registered.
REQ-013 busy  output  1  high in every state except S_IDLE.
REQ-014 trig_err  output  1  one-cycle strobe when a trigger is too short.
REQ-015 echo_done  output  1  one-cycle strobe on the cycle echo falls.

Function
REQ-016 trigger SHALL pass through a 2-FF synchronizer, and edges SHALL be detected on the synchronized signal only.
REQ-017 A us tick generator SHALL count 0..CLK_FREQ_MHZ-1, pulse at the terminal count, and restart from 0 on every state entry.
REQ-018 States SHALL be S_IDLE, S_TRIG_MEAS, S_BURST, S_ECHO and S_HOLDOFF.
REQ-019 S_IDLE -> S_TRIG_MEAS SHALL occur on a synchronized rising edge, and the us counter SHALL clear.
REQ-020 In S_TRIG_MEAS, the us counter SHALL count ticks while the trigger is high, saturating at 16'hFFFF.
REQ-021 On the trigger falling edge in S_TRIG_MEAS with count >= MIN_TRIG_US, the state SHALL go to S_BURST, distance_cm SHALL be latched, and the us counter SHALL clear.
REQ-022 On the trigger falling edge in S_TRIG_MEAS with count < MIN_TRIG_US, trig_err SHALL pulse 1 cycle and the state SHALL go to S_IDLE with no echo.
REQ-023 Echo width SHALL be computed from the latched value in 17-bit unsigned arithmetic.
REQ-024 A latched value < MIN_CM SHALL be clamped to MIN_CM.
REQ-025 A latched value in MIN_CM..MAX_CM SHALL give an echo width of value*US_PER_CM.
REQ-026 A latched value > MAX_CM SHALL give an echo width of TIMEOUT_US.
REQ-027 In S_BURST, echo SHALL be registered 1 on the cycle the counter reaches BURST_DELAY_US, the state SHALL go to S_ECHO, and the counter SHALL clear.
REQ-028 In S_ECHO, echo SHALL be registered 0 on the cycle the counter reaches the echo width, echo_done SHALL pulse, and the state SHALL go to S_HOLDOFF.
REQ-029 S_HOLDOFF -> S_IDLE SHALL occur when the counter reaches HOLDOFF_US.
REQ-030 Trigger edges in S_BURST, S_ECHO and S_HOLDOFF SHALL be ignored, with no restart and no trig_err.
REQ-031 A trigger already high on entry to S_IDLE SHALL NOT start a cycle; only a new rising edge SHALL.
REQ-032 Changes to distance_cm after latching SHALL NOT affect the echo in flight.
REQ-033 Echo width tolerance SHALL be exact to within +0/-1 us-tick granularity, i.e. at most CLK_FREQ_MHZ cycles.
REQ-034 An unreachable state encoding SHALL go to S_IDLE with echo 0 on the next cycle.

Reset
REQ-035 While reset_p is high, the block SHALL force echo=0, busy=0, trig_err=0, echo_done=0, state=S_IDLE, counters=0, latched distance=0 and synchronizer flops=0, asynchronously.
REQ-036 Reset asserted mid-echo SHALL drop echo immediately without asserting echo_done.
REQ-037 After reset release, the first synchronized rising edge of trigger SHALL be required to start a cycle.

Verification
REQ-038 Bench: CLK_FREQ_MHZ=100, distance_cm=100, 12 us trigger -> echo rises 200 us after trigger fall (+sync latency of 2-3 cycles), stays high 5800 us (580000 +/-100 cycles), then echo_done pulses once.
REQ-039 Bench: 5 us trigger -> trig_err pulses 1 cycle, echo stays 0, busy returns 0.
REQ-040 Bench: distance_cm=500, then distance_cm=0 -> echo widths of 38000 us and 116 us respectively.
REQ-041 Bench: second trigger issued during S_ECHO and during S_HOLDOFF -> ignored; a trigger after HOLDOFF_US yields a new echo.
REQ-042 Bench: reset_p asserted 1000 us into the echo -> echo 0 same cycle, no echo_done; after release, a new 12 us trigger gives a correct echo.
REQ-043 Bench: distance_cm changed from 100 to 300 during S_BURST -> echo width stays 5800 us.

Source files
------------

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 ultrasonic sensor emulator: measures the controller's trigger pulse,
// waits out the burst delay and answers with an echo pulse proportional to distance.
module hcsr04_echo_emulator #(
  parameter int CLK_FREQ_MHZ   = 100,
  parameter int MIN_TRIG_US    = 10,
  parameter int BURST_DELAY_US = 200,
  parameter int US_PER_CM      = 58,
  parameter int MIN_CM         = 2,
  parameter int MAX_CM         = 400,
  parameter int TIMEOUT_US     = 38000,
  parameter int HOLDOFF_US     = 10000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        trigger,
  input  logic [15:0] distance_cm,
  output logic        echo,
  output logic        busy,
  output logic        trig_err,
  output logic        echo_done
);

  localparam int TICK_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_FREQ_MHZ - 1);
  localparam logic [16:0] US_SAT = 17'h0FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG_MEAS, S_BURST, S_ECHO, S_HOLDOFF
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [16:0]       us_cnt_q, us_cnt_d;
  logic [15:0]       dist_q, dist_d;
  logic [2:0]        sync_q, sync_d;   // [0] meta, [1] synchronized, [2] previous
  logic              echo_q, echo_d;
  logic              trig_err_q, trig_err_d;
  logic              echo_done_q, echo_done_d;

  logic        tick, trig_rise, trig_fall;
  logic [16:0] us_next, dist_ext, dist_clamped, echo_width;

  always_comb begin
    tick      = (tick_cnt_q == TICK_LAST);
    trig_rise = sync_q[1] & ~sync_q[2];
    trig_fall = ~sync_q[1] & sync_q[2];
    us_next   = us_cnt_q + 17'd1;

    // Width is derived from the latched distance so later input changes are harmless.
    dist_ext     = {1'b0, dist_q};
    dist_clamped = (dist_ext < 17'(MIN_CM)) ? 17'(MIN_CM) : dist_ext;
    echo_width   = (dist_ext > 17'(MAX_CM)) ? 17'(TIMEOUT_US)
                                            : dist_clamped * 17'(US_PER_CM);
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
    us_cnt_d    = us_cnt_q;
    dist_d      = dist_q;
    sync_d      = {sync_q[1:0], trigger};
    echo_d      = echo_q;
    trig_err_d  = 1'b0;
    echo_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        echo_d = 1'b0;
        if (trig_rise) state_d = S_TRIG_MEAS;
      end
      S_TRIG_MEAS: begin
        if (trig_fall) begin
          if (us_cnt_q >= 17'(MIN_TRIG_US)) begin
            state_d = S_BURST;
            dist_d  = distance_cm;
          end else begin
            state_d    = S_IDLE;
            trig_err_d = 1'b1;
          end
        end else if (tick && sync_q[1] && us_cnt_q != US_SAT) begin
          us_cnt_d = us_next;
        end
      end
      S_BURST: begin
        if (tick) begin
          if (us_next >= 17'(BURST_DELAY_US)) begin
            state_d = S_ECHO;
            echo_d  = 1'b1;
          end else begin
            us_cnt_d = us_next;
          end
        end
      end
      S_ECHO: begin
        if (tick) begin
          if (us_next >= echo_width) begin
            state_d     = S_HOLDOFF;
            echo_d      = 1'b0;
            echo_done_d = 1'b1;
          end else begin
            us_cnt_d = us_next;
          end
        end
      end
      S_HOLDOFF: begin
        if (tick) begin
          if (us_next >= 17'(HOLDOFF_US)) state_d = S_IDLE;
          else                            us_cnt_d = us_next;
        end
      end
      default: begin
        state_d = S_IDLE;
        echo_d  = 1'b0;
      end
    endcase

    // Every state entry restarts both the us tick phase and the us counter.
    if (state_d != state_q) begin
      tick_cnt_d = '0;
      us_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      us_cnt_q    <= '0;
      dist_q      <= '0;
      sync_q      <= '0;
      echo_q      <= 1'b0;
      trig_err_q  <= 1'b0;
      echo_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      us_cnt_q    <= us_cnt_d;
      dist_q      <= dist_d;
      sync_q      <= sync_d;
      echo_q      <= echo_d;
      trig_err_q  <= trig_err_d;
      echo_done_q <= echo_done_d;
    end
  end

  assign echo      = echo_q;
  assign busy      = (state_q != S_IDLE);
  assign trig_err  = trig_err_q;
  assign echo_done = echo_done_q;

endmodule
